uart_receiver_ext: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 receiver. It adds the following over that block:
- configurable data width, parity and stop-bit count
- an input synchroniser with falling-edge start detection and false-start rejection
- per-frame parity, framing and break flags
- re-arming in the middle of the stop bit, so back-to-back frames are received
It sits between the uart_rx pin and the UART controller register block.

---
 rtl/uart_receiver_ext_if.sv | 20 ++
 rtl/uart_receiver_ext.sv | 196 +++++++++++++++++++
 tb/tb_uart_receiver_ext.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_ext_if.sv
// Receiver-to-controller bundle: received word, completion strobe,
// per-frame error flags and the busy indication.
interface uart_receiver_ext_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              break_det;
  logic              busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, busy
  );

  modport slave (
    input rx_data, rx_valid, parity_err, frame_err, break_det, busy
  );
endinterface

// File: rtl/uart_receiver_ext.sv
// Parametrised UART receiver: synchronised rx pin, falling-edge start
// detection with false-start rejection, configurable data/parity/stop
// framing, per-frame parity/framing/break flags and mid-stop re-arming.
module uart_receiver_ext #(
  parameter int DATA_W      = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rec_en,
  input  logic [CNT_W-1:0]    comp,
  input  logic                uart_rx,
  uart_receiver_ext_if.master rx_if
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD_SEL   = (PARITY_ODD != 0);

  // Parity mismatch of a data word plus its received parity bit.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] word,
                                           input logic par_bit);
    return (^word) ^ par_bit ^ ODD_SEL;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_sync_s;
  logic                   rx_dly_r;
  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [3:0]             bit_idx_r;
  logic [DATA_W-1:0]      shift_r;
  logic                   par_bit_r;
  logic                   stop_bad_r;
  logic                   ones_r;
  logic                   sample_s;
  logic                   wrap_s;
  logic                   done_s;
  logic                   frame_err_s;
  logic                   break_s;
  logic                   parity_err_s;

  assign rx_sync_s = sync_r[SYNC_STAGES-1];
  assign sample_s  = (cnt_r == (comp >> 1));
  assign wrap_s    = (cnt_r == comp);

  // Synchroniser chain on the asynchronous pin plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r   <= {SYNC_STAGES{1'b1}};
      rx_dly_r <= 1'b1;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], uart_rx};
      rx_dly_r <= rx_sync_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the last stop-bit sample completes the frame immediately.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    if (!rec_en) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_dly_r && !rx_sync_s) state_s = ST_START;
          else                        state_s = ST_IDLE;
        end
        ST_START: begin
          if (sample_s && rx_sync_s) state_s = ST_IDLE;
          else if (wrap_s)           state_s = ST_DATA;
          else                       state_s = ST_START;
        end
        ST_DATA: begin
          if (wrap_s && (bit_idx_r == LAST_DATA))
            state_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          else
            state_s = ST_DATA;
        end
        ST_PARITY: begin
          if (wrap_s) state_s = ST_STOP;
          else        state_s = ST_PARITY;
        end
        ST_STOP: begin
          if (sample_s && (bit_idx_r == LAST_STOP)) begin
            done_s  = 1'b1;
            state_s = (stop_bad_r || !rx_sync_s) ? ST_WAIT_HIGH : ST_IDLE;
          end else begin
            state_s = ST_STOP;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_sync_s) state_s = ST_IDLE;
          else           state_s = ST_WAIT_HIGH;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Frame flags as they stand at the final stop-bit sample.
  always_comb begin
    frame_err_s  = stop_bad_r | ~rx_sync_s;
    break_s      = ~(ones_r | rx_sync_s);
    parity_err_s = (PARITY_EN != 0) ? parity_mismatch(shift_r, par_bit_r) : 1'b0;
  end

  // Baud counter, bit index and sampled-bit accumulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r      <= {CNT_W{1'b0}};
      bit_idx_r  <= 4'd0;
      shift_r    <= {DATA_W{1'b0}};
      par_bit_r  <= 1'b0;
      stop_bad_r <= 1'b0;
      ones_r     <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) || (state_s == ST_IDLE) || wrap_s) cnt_r <= {CNT_W{1'b0}};
      else                                                        cnt_r <= cnt_r + CNT_W'(1);

      if (state_s != state_r) bit_idx_r <= 4'd0;
      else if (wrap_s)        bit_idx_r <= bit_idx_r + 4'd1;

      if (state_r == ST_IDLE) begin
        stop_bad_r <= 1'b0;
        ones_r     <= 1'b0;
      end else if (sample_s) begin
        case (state_r)
          ST_DATA: begin
            shift_r <= {rx_sync_s, shift_r[DATA_W-1:1]};
            ones_r  <= ones_r | rx_sync_s;
          end
          ST_PARITY: begin
            par_bit_r <= rx_sync_s;
            ones_r    <= ones_r | rx_sync_s;
          end
          ST_STOP: begin
            stop_bad_r <= stop_bad_r | ~rx_sync_s;
            ones_r     <= ones_r | rx_sync_s;
          end
          default: ;
        endcase
      end
    end
  end

  // Registered outputs: one-cycle completion pulse, flags only alongside it, data held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_if.rx_data    <= {DATA_W{1'b0}};
      rx_if.rx_valid   <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.break_det  <= 1'b0;
      rx_if.busy       <= 1'b0;
    end else begin
      rx_if.rx_valid <= done_s;
      rx_if.busy     <= (state_s != ST_IDLE);
      if (done_s) begin
        rx_if.rx_data    <= shift_r;
        rx_if.parity_err <= parity_err_s;
        rx_if.frame_err  <= frame_err_s;
        rx_if.break_det  <= break_s;
      end else begin
        rx_if.parity_err <= 1'b0;
        rx_if.frame_err  <= 1'b0;
        rx_if.break_det  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver_ext.sv
// Scoreboard bench for uart_receiver_ext: three configurations (8N1, 8E1,
// 5N2) driven by bit-level line stimulus; expected frames come from a
// frame-level model and are popped by a monitor on every rx_valid.
module tb_uart_receiver_ext;

  localparam int DW [3] = '{8, 8, 5};
  localparam int PE [3] = '{0, 1, 0};
  localparam int PO [3] = '{0, 0, 0};
  localparam int SB [3] = '{1, 1, 2};

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  rec_en;
  logic [2:0]  rx_line;
  logic [15:0] comp_v [3];

  always #5 clk = ~clk;

  uart_receiver_ext_if #(.DATA_W(8)) if0 ();
  uart_receiver_ext_if #(.DATA_W(8)) if1 ();
  uart_receiver_ext_if #(.DATA_W(5)) if2 ();

  uart_receiver_ext #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                      .SYNC_STAGES(2), .CNT_W(16)) u0 (
    .clk(clk), .rstn(rstn), .rec_en(rec_en[0]), .comp(comp_v[0]),
    .uart_rx(rx_line[0]), .rx_if(if0));
  uart_receiver_ext #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                      .SYNC_STAGES(2), .CNT_W(16)) u1 (
    .clk(clk), .rstn(rstn), .rec_en(rec_en[1]), .comp(comp_v[1]),
    .uart_rx(rx_line[1]), .rx_if(if1));
  uart_receiver_ext #(.DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2),
                      .SYNC_STAGES(3), .CNT_W(16)) u2 (
    .clk(clk), .rstn(rstn), .rec_en(rec_en[2]), .comp(comp_v[2]),
    .uart_rx(rx_line[2]), .rx_if(if2));

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t       q0 [$];
  exp_t       q1 [$];
  exp_t       q2 [$];
  int         tests = 0;
  int         fails = 0;
  logic [8:0] last_data [3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Frame-level reference: what the receiver must report for the given line content.
  function automatic exp_t model(input int inst, input logic [8:0] data,
                                 input logic par, input logic [1:0] stops);
    exp_t e;
    int   ones = 0;
    bit   seen_one = 0;
    e = '0;
    for (int i = 0; i < DW[inst]; i++) begin
      e.data[i] = data[i];
      if (data[i]) begin ones++; seen_one = 1; end
    end
    if (PE[inst] != 0) begin
      if (par) begin ones++; seen_one = 1; end
      e.perr = ((ones % 2) != PO[inst]);
    end
    for (int i = 0; i < SB[inst]; i++) begin
      if (!stops[i]) e.ferr = 1'b1;
      else           seen_one = 1;
    end
    e.brk = !seen_one;
    return e;
  endfunction

  task automatic push_exp(input int inst, input exp_t e);
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    last_data[inst] = e.data;
  endtask

  task automatic pop_exp(input int inst, output exp_t e, output bit empty);
    empty = 0;
    e = '0;
    case (inst)
      0:       if (q0.size() == 0) empty = 1; else e = q0.pop_front();
      1:       if (q1.size() == 0) empty = 1; else e = q1.pop_front();
      default: if (q2.size() == 0) empty = 1; else e = q2.pop_front();
    endcase
  endtask

  function automatic logic valid_of(input int inst);
    case (inst)
      0:       return if0.rx_valid;
      1:       return if1.rx_valid;
      default: return if2.rx_valid;
    endcase
  endfunction

  task automatic mon(input int inst, input logic v, input logic [8:0] d,
                     input logic pe, input logic fe, input logic bk);
    exp_t e;
    bit   empty;
    if (v) begin
      pop_exp(inst, e, empty);
      if (empty) begin
        tests++;
        fails++;
        $display("FAIL u%0d_unexpected_valid: got rx_valid=1 data %0h, expected no frame (t=%0t)",
                 inst, d, $time);
      end else begin
        check($sformatf("u%0d_data", inst), d, e.data);
        check($sformatf("u%0d_parity_err", inst), pe, e.perr);
        check($sformatf("u%0d_frame_err", inst), fe, e.ferr);
        check($sformatf("u%0d_break_det", inst), bk, e.brk);
      end
    end else begin
      check($sformatf("u%0d_flags_idle", inst), {pe, fe, bk}, 32'd0);
    end
  endtask

  // Monitor: compare every completion against the scoreboard, away from the active edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      mon(0, if0.rx_valid, 9'(if0.rx_data), if0.parity_err, if0.frame_err, if0.break_det);
      mon(1, if1.rx_valid, 9'(if1.rx_data), if1.parity_err, if1.frame_err, if1.break_det);
      mon(2, if2.rx_valid, 9'(if2.rx_data), if2.parity_err, if2.frame_err, if2.break_det);
    end
  end

  // Hold one line level for one bit period; called at posedge+1.
  task automatic drive_bit(input int inst, input logic v);
    rx_line[inst] = v;
    repeat (int'(comp_v[inst]) + 1) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input logic par,
                            input logic [1:0] stops, input bit push, input int hold_low);
    bit stops_ok = 1;
    if (push) push_exp(inst, model(inst, data, par, stops));
    drive_bit(inst, 1'b0);
    for (int i = 0; i < DW[inst]; i++) drive_bit(inst, data[i]);
    if (PE[inst] != 0) drive_bit(inst, par);
    for (int i = 0; i < SB[inst]; i++) begin
      drive_bit(inst, stops[i]);
      if (!stops[i]) stops_ok = 0;
    end
    for (int i = 0; i < hold_low; i++) drive_bit(inst, 1'b0);
    if (!stops_ok || hold_low > 0) drive_bit(inst, 1'b1);
    rx_line[inst] = 1'b1;
  endtask

  task automatic wait_valid(input int inst, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (valid_of(inst)) ok = 1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int gap;
    rstn    = 1'b0;
    rec_en  = 3'b111;
    rx_line = 3'b111;
    for (int i = 0; i < 3; i++) begin
      comp_v[i]    = 16'd15;
      last_data[i] = 9'd0;
    end
    idle_cycles(3);
    check("rst_valid", {if0.rx_valid, if1.rx_valid, if2.rx_valid}, 32'd0);
    check("rst_data", {if0.rx_data, if1.rx_data, 3'b000, if2.rx_data}, 32'd0);
    check("rst_flags", {if0.parity_err, if0.frame_err, if0.break_det,
                        if1.parity_err, if2.frame_err}, 32'd0);
    check("rst_busy", {if0.busy, if1.busy, if2.busy}, 32'd0);
    rstn = 1'b1;
    idle_cycles(4);

    // Nominal back-to-back 8N1 frames and the busy-low gap between them.
    fork
      begin
        send_frame(0, 9'h055, 1'b0, 2'b11, 1'b1, 0);
        send_frame(0, 9'h0A3, 1'b0, 2'b11, 1'b1, 0);
      end
      begin
        wait_valid(0, 400, ok);
        check("nom_first_valid_seen", ok, 32'd1);
        gap = 0;
        while (if0.busy == 1'b0 && gap < 100) begin
          gap++;
          @(negedge clk);
        end
        check("nom_busy_gap_within_bit", (gap <= 16), 32'd1);
      end
    join
    idle_cycles(20);

    // Even parity: correct then wrong parity bit.
    send_frame(1, 9'h0A3, 1'b0, 2'b11, 1'b1, 0);
    send_frame(1, 9'h0A3, 1'b1, 2'b11, 1'b1, 0);
    idle_cycles(20);

    // Framing error, busy held until the line returns high.
    fork
      send_frame(0, 9'h03C, 1'b0, 2'b10, 1'b1, 1);
      begin
        wait_valid(0, 400, ok);
        check("ferr_valid_seen", ok, 32'd1);
        repeat (3) @(negedge clk);
        check("ferr_busy_wait_high", if0.busy, 32'd1);
      end
    join
    check("ferr_busy_released", if0.busy, 32'd0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b1, 0);
    idle_cycles(20);

    // Abort by rec_en mid-data.
    fork
      send_frame(0, 9'h077, 1'b0, 2'b11, 1'b0, 0);
      begin
        repeat (64) @(posedge clk);
        #1;
        rec_en[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", if0.busy, 32'd0);
        check("abort_data_held", if0.rx_data, last_data[0]);
      end
    join
    idle_cycles(20);
    rec_en[0] = 1'b1;
    idle_cycles(20);
    send_frame(0, 9'h012, 1'b0, 2'b11, 1'b1, 0);
    idle_cycles(20);

    // Break: 12 bit times low yields exactly one flagged frame.
    send_frame(0, 9'h000, 1'b0, 2'b00, 1'b1, 2);
    idle_cycles(20);

    // 4-cycle low glitch is rejected as a false start.
    rx_line[0] = 1'b0;
    idle_cycles(4);
    rx_line[0] = 1'b1;
    @(negedge clk);
    check("glitch_start_seen", if0.busy, 32'd1);
    repeat (30) @(negedge clk);
    check("glitch_busy_cleared", if0.busy, 32'd0);
    idle_cycles(5);

    // Asynchronous reset mid-frame.
    fork
      send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b0, 0);
      begin
        repeat (50) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_outputs", {if0.rx_valid, if0.parity_err, if0.frame_err,
                                  if0.break_det, if0.busy}, 32'd0);
        check("rst_mid_data", if0.rx_data, 32'd0);
      end
    join
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) last_data[i] = 9'd0;
    idle_cycles(10);
    send_frame(0, 9'h0C9, 1'b0, 2'b11, 1'b1, 0);
    idle_cycles(20);

    // 5-bit, two stop bits: good frame, then only the second stop bit low.
    send_frame(2, 9'h01B, 1'b0, 2'b11, 1'b1, 0);
    send_frame(2, 9'h01B, 1'b0, 2'b01, 1'b1, 0);
    idle_cycles(20);

    // Randomised frames across all configurations, random bit period on the 8N1 unit.
    for (int n = 0; n < 30; n++) begin
      int         inst;
      logic [8:0] d;
      logic       p;
      logic [1:0] s;
      inst = n % 3;
      d    = 9'($urandom);
      p    = 1'($urandom);
      s    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if (inst == 0) comp_v[0] = 16'($urandom_range(3, 24));
      send_frame(inst, d, p, s, 1'b1, 0);
      idle_cycles(2);
    end

    for (int i = 0; i < 1000 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
    check("scoreboard_drained", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
